// File: rtl/reg_dump_text_engine_if.sv
// Debug read port plus text-buffer write port of the register dump engine.
// The engine uses the slave view; the core / buffer side uses the master view.
interface reg_dump_text_engine_if #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 13
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [WORD_SIZE-1:0]  reg_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [31:0]           wr_data;
  logic                  wr_ready;

  modport slave (
    input  start, reg_data, wr_ready,
    output busy, done, reg_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, reg_data, wr_ready,
    input  busy, done, reg_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/reg_dump_text_engine.sv
// Snapshots each register through the debug read port and prints it as upper-case ASCII hex,
// one text row per register. Define REG_DUMP_LABEL_EN to prefix each row with "xNN: ".
module reg_dump_text_engine #(
  parameter int          WORD_SIZE  = 32,
  parameter int          REG_COUNT  = 32,
  parameter int          REG_ADDR_W = 5,
  parameter int          ADDR_W     = 13,
  parameter int          ROW_STRIDE = 80,
  parameter int          BASE_ADDR  = 0,
  parameter int          RD_LATENCY = 1,
  parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
  input logic                   clk,
  input logic                   rst,
  reg_dump_text_engine_if.slave bus
);

  localparam int DIGITS = WORD_SIZE / 4;
`ifdef REG_DUMP_LABEL_EN
  localparam int LABEL_CHARS = 5;
`else
  localparam int LABEL_CHARS = 0;
`endif
  localparam int CHARS = DIGITS + LABEL_CHARS;
  localparam int COL_W = $clog2(CHARS + 1);
  localparam int IDX_W = 7;
  localparam int LAT_W = 2;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, EMIT, DONE} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     r;
  logic [COL_W-1:0]     c;
  logic [LAT_W-1:0]     lat;
  logic [WORD_SIZE-1:0] snap;
  logic [7:0]           ch;
  logic                 accept, last_char, last_reg, lat_last;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble_at(input logic [WORD_SIZE-1:0] w, input int idx);
    return 4'(w >> (4 * idx));
  endfunction

  assign accept    = (state == EMIT) && bus.wr_ready;
  assign last_char = (c == COL_W'(CHARS - 1));
  assign last_reg  = (r == IDX_W'(REG_COUNT - 1));
  assign lat_last  = (lat == LAT_W'(1));
  assign bus.reg_addr = REG_ADDR_W'(r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    unique case (state)
      IDLE:    if (bus.start) state_nx = REQ;
      REQ:     state_nx = WAIT_RD;
      WAIT_RD: if (lat_last) state_nx = EMIT;
      EMIT: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(BASE_ADDR + int'(r) * ROW_STRIDE + int'(c));
        bus.wr_data = {ch, ATTR};
        if (accept && last_char) state_nx = last_reg ? DONE : REQ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Character for column c: optional label cells first, then hex digits MSB nibble first.
  always_comb begin
    ch = hex_ascii(nibble_at(snap, DIGITS - 1 - (int'(c) - LABEL_CHARS)));
`ifdef REG_DUMP_LABEL_EN
    if      (c == COL_W'(0)) ch = 8'h78;
    else if (c == COL_W'(1)) ch = 8'h30 + {1'b0, r / IDX_W'(10)};
    else if (c == COL_W'(2)) ch = 8'h30 + {1'b0, r % IDX_W'(10)};
    else if (c == COL_W'(3)) ch = 8'h3A;
    else if (c == COL_W'(4)) ch = 8'h20;
`endif
  end

  // The snapshot is frozen for the whole row so live register writes cannot tear the text.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r    <= '0;
      c    <= '0;
      lat  <= '0;
      snap <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) r <= '0;
        REQ:  lat <= LAT_W'(RD_LATENCY);
        WAIT_RD: begin
          lat <= lat - LAT_W'(1);
          if (lat_last) begin
            snap <= bus.reg_data;
            c    <= '0;
          end
        end
        EMIT: if (accept) begin
          c <= c + COL_W'(1);
          if (last_char && !last_reg) r <= r + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_text_engine.sv
// Directed bench for reg_dump_text_engine: three instances cover defaults, long read latency
// and a narrow word with address wrap.
module tb_reg_dump_text_engine;

`ifdef REG_DUMP_LABEL_EN
  localparam int LBL = 5;
`else
  localparam int LBL = 0;
`endif
  localparam int DONE0 = 32 * (2 + 8 + LBL) + 1;
  localparam int DONE1 = 12 * (4 + 8 + LBL) + 1;
  localparam int DONE2 = 2 * (2 + 4 + LBL) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  reg_dump_text_engine_if #(.WORD_SIZE(32), .REG_ADDR_W(5), .ADDR_W(13)) b0 ();
  reg_dump_text_engine_if #(.WORD_SIZE(32), .REG_ADDR_W(5), .ADDR_W(13)) b1 ();
  reg_dump_text_engine_if #(.WORD_SIZE(16), .REG_ADDR_W(5), .ADDR_W(13)) b2 ();

  reg_dump_text_engine dut0 (.clk(clk), .rst(rst), .bus(b0));
  reg_dump_text_engine #(.RD_LATENCY(3), .REG_COUNT(12)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  reg_dump_text_engine #(.WORD_SIZE(16), .BASE_ADDR(8180), .REG_COUNT(2))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  logic [31:0] regs0 [32];
  logic [31:0] regs1 [32];
  logic [15:0] regs2 [32];
  logic [31:0] p1a, p1b;
  logic [31:0] mem0 [8192];
  logic [31:0] mem1 [8192];
  logic [31:0] mem2 [8192];

  // Register file models: latency 1 for dut0/dut2, three-stage read pipe for dut1.
  always @(posedge clk) begin
    b0.reg_data <= regs0[b0.reg_addr];
    b2.reg_data <= regs2[b2.reg_addr];
    p1a         <= regs1[b1.reg_addr];
    p1b         <= p1a;
    b1.reg_data <= p1b;
  end

  // Text buffer models.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8192; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
    end else begin
      if (b0.wr_en && b0.wr_ready) mem0[b0.wr_addr] <= b0.wr_data;
      if (b1.wr_en && b1.wr_ready) mem1[b1.wr_addr] <= b1.wr_data;
      if (b2.wr_en && b2.wr_ready) mem2[b2.wr_addr] <= b2.wr_data;
    end
  end

  function automatic string lbl(input int r);
    return (LBL == 0) ? "" : $sformatf("x%02d: ", r);
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({b0.busy, b0.done, b0.wr_en, b0.reg_addr} !== 8'h00)
      $display("FAIL reset_ctrl0: got busy/done/wr_en/reg_addr=%b, want 0", {b0.busy, b0.done, b0.wr_en, b0.reg_addr});
    else pass_cnt++;
    total++;
    if ({b0.wr_addr, b0.wr_data} !== 45'h0)
      $display("FAIL reset_data0: got wr_addr=%0d wr_data=%h, want 0/0", b0.wr_addr, b0.wr_data);
    else pass_cnt++;
    total++;
    if ({b1.busy, b1.done, b1.wr_en, b1.reg_addr, b1.wr_addr, b1.wr_data} !== 53'h0)
      $display("FAIL reset_all1: got nonzero outputs on dut1, want all 0");
    else pass_cnt++;
    total++;
    if ({b2.busy, b2.done, b2.wr_en, b2.reg_addr, b2.wr_addr, b2.wr_data} !== 53'h0)
      $display("FAIL reset_all2: got nonzero outputs on dut2, want all 0");
    else pass_cnt++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({b0.busy, b0.done, b0.wr_en} !== 3'b000)
      $display("FAIL idle_after_reset: got busy/done/wr_en=%b, want 000", {b0.busy, b0.done, b0.wr_en});
    else pass_cnt++;
  endtask

  task automatic test_default_dump;
    int cyc;
    string e;
    for (int i = 0; i < 32; i++) regs0[i] = 32'hA5A5A5A5;
    regs0[0]  = 32'h1234ABCD;
    regs0[2]  = 32'h56789EF0;
    regs0[10] = 32'h0F1E2D3C;
    regs0[31] = 32'h00000000;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    b0.start = 1'b1; @(negedge clk); b0.start = 1'b0;
    total++;
    if (b0.busy !== 1'b1 || b0.reg_addr !== 5'd0 || b0.wr_en !== 1'b0)
      $display("FAIL first_cycle: got busy=%b reg_addr=%0d wr_en=%b, want 1/0/0", b0.busy, b0.reg_addr, b0.wr_en);
    else pass_cnt++;
    cyc = 1;
    while (b0.done !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
    total++;
    if (cyc !== DONE0) $display("FAIL done_cycle: got %0d, want %0d", cyc, DONE0);
    else pass_cnt++;
    total++;
    if (b0.busy !== 1'b1 || b0.wr_en !== 1'b0)
      $display("FAIL done_busy: got busy=%b wr_en=%b, want 1/0", b0.busy, b0.wr_en);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (b0.busy !== 1'b0 || b0.done !== 1'b0)
      $display("FAIL after_done: got busy=%b done=%b, want 0/0", b0.busy, b0.done);
    else pass_cnt++;
    e = {lbl(0), "1234ABCD"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem0[13'(k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL row0_c%0d: got %h, want %h", k, mem0[13'(k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    e = {lbl(2), "56789EF0"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem0[13'(160 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL row2_c%0d: got %h, want %h", k, mem0[13'(160 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    e = {lbl(10), "0F1E2D3C"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem0[13'(800 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL row10_c%0d: got %h, want %h", k, mem0[13'(800 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    e = {lbl(31), "00000000"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem0[13'(2480 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL row31_c%0d: got %h, want %h", k, mem0[13'(2480 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    total++;
    if (mem0[13'(2480 + 8 + LBL)] !== 32'h0)
      $display("FAIL row31_tail: got %h, want 0", mem0[13'(2480 + 8 + LBL)]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int cyc;
    bit stalled;
    string e;
    e = {lbl(0), "1234ABCD"};
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    b0.start = 1'b1; @(negedge clk); b0.start = 1'b0;
    cyc = 1;
    stalled = 1'b0;
    while (b0.done !== 1'b1 && cyc < 2000) begin
      if (!stalled && b0.wr_en === 1'b1 && b0.wr_addr === 13'd1) begin
        stalled = 1'b1;
        b0.wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk); cyc++;
          total++;
          if (b0.wr_en !== 1'b1 || b0.wr_addr !== 13'd1 || b0.wr_data !== {e[1], 24'hFFFFFF})
            $display("FAIL stall_hold%0d: got en=%b addr=%0d data=%h, want en=1 addr=1 data=%h",
                     i, b0.wr_en, b0.wr_addr, b0.wr_data, {e[1], 24'hFFFFFF});
          else pass_cnt++;
        end
        b0.wr_ready = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (stalled !== 1'b1 || cyc !== DONE0 + 3)
      $display("FAIL stall_done_cycle: got stalled=%b cycle=%0d, want 1/%0d", stalled, cyc, DONE0 + 3);
    else pass_cnt++;
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem0[13'(k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL stall_row0_c%0d: got %h, want %h", k, mem0[13'(k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
  endtask

  task automatic test_snapshot_latency;
    int cyc;
    bit changed;
    string e;
    for (int i = 0; i < 32; i++) regs1[i] = 32'h77777777;
    regs1[5]  = 32'h5555AAAA;
    regs1[11] = 32'hDEADBEEF;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    b1.start = 1'b1; @(negedge clk); b1.start = 1'b0;
    cyc = 1;
    changed = 1'b0;
    while (b1.done !== 1'b1 && cyc < 1000) begin
      if (!changed && b1.wr_en === 1'b1 && b1.wr_addr === 13'd400) begin
        regs1[5] = 32'h0BADF00D;
        changed = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (changed !== 1'b1 || cyc !== DONE1)
      $display("FAIL lat3_done_cycle: got changed=%b cycle=%0d, want 1/%0d", changed, cyc, DONE1);
    else pass_cnt++;
    e = {lbl(5), "5555AAAA"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem1[13'(400 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL snap_row5_c%0d: got %h, want %h", k, mem1[13'(400 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    e = {lbl(11), "DEADBEEF"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem1[13'(880 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL lat3_row11_c%0d: got %h, want %h", k, mem1[13'(880 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap;
    int cyc;
    string e;
    regs2[0] = 16'h00F0;
    regs2[1] = 16'h9A7C;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    b2.start = 1'b1; @(negedge clk); b2.start = 1'b0;
    cyc = 1;
    while (b2.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    total++;
    if (cyc !== DONE2) $display("FAIL w16_done_cycle: got %0d, want %0d", cyc, DONE2);
    else pass_cnt++;
    e = {lbl(0), "00F0"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem2[13'((8180 + k) % 8192)] !== {e[k], 24'hFFFFFF})
        $display("FAIL w16_row0_c%0d: got %h, want %h", k, mem2[13'((8180 + k) % 8192)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
    e = {lbl(1), "9A7C"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem2[13'(68 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL wrap_row1_c%0d: got %h, want %h", k, mem2[13'(68 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    string e;
    b2.start = 1'b1; @(negedge clk); b2.start = 1'b0;
    cyc = 1;
    while (b2.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    @(negedge clk);
    total++;
    if (b2.busy !== 1'b0 || b2.done !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0/0", b2.busy, b2.done);
    else pass_cnt++;
    regs2[1] = 16'h1234;
    b2.start = 1'b1; @(negedge clk); b2.start = 1'b0;
    total++;
    if (b2.busy !== 1'b1 || b2.reg_addr !== 5'd0)
      $display("FAIL b2b_restart: got busy=%b reg_addr=%0d, want 1/0", b2.busy, b2.reg_addr);
    else pass_cnt++;
    cyc = 1;
    while (b2.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    total++;
    if (cyc !== DONE2) $display("FAIL b2b_done_cycle: got %0d, want %0d", cyc, DONE2);
    else pass_cnt++;
    e = {lbl(1), "1234"};
    for (int k = 0; k < e.len(); k++) begin
      total++;
      if (mem2[13'(68 + k)] !== {e[k], 24'hFFFFFF})
        $display("FAIL b2b_row1_c%0d: got %h, want %h", k, mem2[13'(68 + k)], {e[k], 24'hFFFFFF});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    int dones;
    int period;
    int exp_row;
    int exp_addr;
    period   = 2 + 8 + LBL;
    exp_row  = 48 / period;
    exp_addr = exp_row * 80 + (48 % period) - 2;
    @(negedge clk);
    b0.start = 1'b1; @(negedge clk); b0.start = 1'b0;
    cyc = 1;
    dones = 0;
    while (cyc < 50) begin
      b0.start = (cyc == 10);
      @(negedge clk); cyc++;
      if (b0.done === 1'b1) dones++;
      if (cyc == 49) begin
        total++;
        if (b0.reg_addr !== 5'(exp_row) || b0.wr_addr !== 13'(exp_addr) || b0.wr_en !== 1'b1)
          $display("FAIL busy_start_ignored: got reg_addr=%0d wr_addr=%0d wr_en=%b, want %0d/%0d/1",
                   b0.reg_addr, b0.wr_addr, b0.wr_en, exp_row, exp_addr);
        else pass_cnt++;
      end
    end
    b0.start = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({b0.busy, b0.done, b0.wr_en, b0.reg_addr, b0.wr_addr, b0.wr_data} !== 53'h0)
      $display("FAIL abort_outputs: got busy=%b done=%b wr_en=%b reg_addr=%0d wr_addr=%0d wr_data=%h, want all 0",
               b0.busy, b0.done, b0.wr_en, b0.reg_addr, b0.wr_addr, b0.wr_data);
    else pass_cnt++;
    repeat (3) begin @(negedge clk); if (b0.done === 1'b1) dones++; end
    rst = 1'b1;
    repeat (5) begin @(negedge clk); if (b0.done === 1'b1) dones++; end
    total++;
    if (dones !== 0 || b0.busy !== 1'b0)
      $display("FAIL abort_no_done: got done pulses=%0d busy=%b, want 0/0", dones, b0.busy);
    else pass_cnt++;
  endtask

  initial begin
    b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
    b0.wr_ready = 1'b1; b1.wr_ready = 1'b1; b2.wr_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regs0[i] = '0;
      regs1[i] = '0;
      regs2[i] = '0;
    end
    test_reset();
    test_default_dump();
    test_backpressure();
    test_snapshot_latency();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
